// File: rtl/spdif_frame_sched.sv
// Sequences stereo pairs from two producers into the 4-deep SPDIF sample register:
// one snapshot per tick, then four back-to-back writes L0, R0, L1, R1.
module spdif_frame_sched #(
   parameter int PCM_W     = 32,
   parameter int CNT_W     = 16,
   parameter int URUN_HOLD = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             tick_i,
   input  logic [PCM_W-1:0] s0_L_i,
   input  logic [PCM_W-1:0] s0_R_i,
   input  logic             s0_vld_i,
   output logic             s0_rdy_o,
   input  logic [PCM_W-1:0] s1_L_i,
   input  logic [PCM_W-1:0] s1_R_i,
   input  logic             s1_vld_i,
   output logic             s1_rdy_o,
   output logic             wr_o,
   output logic [PCM_W-1:0] wr_data_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] urun_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o,
   input  logic             clr_i
);
   typedef enum logic [2:0] {IDLE, W_L0, W_R0, W_L1, W_R1} state_t;

   localparam bit HOLD = (URUN_HOLD != 0);

   state_t           state_q, state_d;
   logic             full0_q, full0_d, full1_q, full1_d;
   logic [PCM_W-1:0] buf_l0_q, buf_l0_d, buf_r0_q, buf_r0_d;
   logic [PCM_W-1:0] buf_l1_q, buf_l1_d, buf_r1_q, buf_r1_d;
   logic [PCM_W-1:0] last_l0_q, last_l0_d, last_r0_q, last_r0_d;
   logic [PCM_W-1:0] last_l1_q, last_l1_d, last_r1_q, last_r1_d;
   logic [PCM_W-1:0] fr_r0_q, fr_r0_d, fr_l1_q, fr_l1_d, fr_r1_q, fr_r1_d;
   logic             wr_q, wr_d, busy_q, busy_d;
   logic [PCM_W-1:0] wr_data_q, wr_data_d;
   logic [CNT_W-1:0] urun_q, urun_d, miss_q, miss_d;

   logic             start, rdy0, rdy1;
   logic [PCM_W-1:0] snap_l0, snap_r0, snap_l1, snap_r1;
   logic [1:0]       n_empty;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0] inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   // A snapshot frees both holding buffers in the same cycle, so a waiting pair may refill them.
   always_comb begin
      start   = en_i & tick_i & (state_q == IDLE);
      rdy0    = en_i & (~full0_q | start);
      rdy1    = en_i & (~full1_q | start);
      snap_l0 = full0_q ? buf_l0_q : (HOLD ? last_l0_q : '0);
      snap_r0 = full0_q ? buf_r0_q : (HOLD ? last_r0_q : '0);
      snap_l1 = full1_q ? buf_l1_q : (HOLD ? last_l1_q : '0);
      snap_r1 = full1_q ? buf_r1_q : (HOLD ? last_r1_q : '0);
      n_empty = {1'b0, ~full0_q} + {1'b0, ~full1_q};
   end

   always_comb begin
      state_d   = state_q;
      full0_d   = full0_q;
      full1_d   = full1_q;
      buf_l0_d  = buf_l0_q;
      buf_r0_d  = buf_r0_q;
      buf_l1_d  = buf_l1_q;
      buf_r1_d  = buf_r1_q;
      last_l0_d = last_l0_q;
      last_r0_d = last_r0_q;
      last_l1_d = last_l1_q;
      last_r1_d = last_r1_q;
      fr_r0_d   = fr_r0_q;
      fr_l1_d   = fr_l1_q;
      fr_r1_d   = fr_r1_q;
      wr_d      = 1'b0;
      wr_data_d = wr_data_q;
      urun_d    = urun_q;
      miss_d    = miss_q;

      if (!en_i) begin
         full0_d = 1'b0;
         full1_d = 1'b0;
      end else begin
         if (s0_vld_i && rdy0) begin
            full0_d  = 1'b1;
            buf_l0_d = s0_L_i;
            buf_r0_d = s0_R_i;
         end else if (start) begin
            full0_d = 1'b0;
         end
         if (s1_vld_i && rdy1) begin
            full1_d  = 1'b1;
            buf_l1_d = s1_L_i;
            buf_r1_d = s1_R_i;
         end else if (start) begin
            full1_d = 1'b0;
         end
      end

      // Once started, a sequence always runs to W_R1 regardless of en_i.
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = W_L0;
               wr_d      = 1'b1;
               wr_data_d = snap_l0;
               fr_r0_d   = snap_r0;
               fr_l1_d   = snap_l1;
               fr_r1_d   = snap_r1;
               last_l0_d = snap_l0;
               last_r0_d = snap_r0;
               last_l1_d = snap_l1;
               last_r1_d = snap_r1;
            end
         end
         W_L0: begin
            state_d   = W_R0;
            wr_d      = 1'b1;
            wr_data_d = fr_r0_q;
         end
         W_R0: begin
            state_d   = W_L1;
            wr_d      = 1'b1;
            wr_data_d = fr_l1_q;
         end
         W_L1: begin
            state_d   = W_R1;
            wr_d      = 1'b1;
            wr_data_d = fr_r1_q;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);

      if (clr_i) begin
         urun_d = '0;
         miss_d = '0;
      end else begin
         if (start) urun_d = sat_add(urun_q, n_empty);
         if (en_i && tick_i && (state_q != IDLE)) miss_d = sat_add(miss_q, 2'd1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         full0_q   <= 1'b0;
         full1_q   <= 1'b0;
         buf_l0_q  <= '0;
         buf_r0_q  <= '0;
         buf_l1_q  <= '0;
         buf_r1_q  <= '0;
         last_l0_q <= '0;
         last_r0_q <= '0;
         last_l1_q <= '0;
         last_r1_q <= '0;
         fr_r0_q   <= '0;
         fr_l1_q   <= '0;
         fr_r1_q   <= '0;
         wr_q      <= 1'b0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         urun_q    <= '0;
         miss_q    <= '0;
      end else begin
         state_q   <= state_d;
         full0_q   <= full0_d;
         full1_q   <= full1_d;
         buf_l0_q  <= buf_l0_d;
         buf_r0_q  <= buf_r0_d;
         buf_l1_q  <= buf_l1_d;
         buf_r1_q  <= buf_r1_d;
         last_l0_q <= last_l0_d;
         last_r0_q <= last_r0_d;
         last_l1_q <= last_l1_d;
         last_r1_q <= last_r1_d;
         fr_r0_q   <= fr_r0_d;
         fr_l1_q   <= fr_l1_d;
         fr_r1_q   <= fr_r1_d;
         wr_q      <= wr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         urun_q    <= urun_d;
         miss_q    <= miss_d;
      end
   end

   assign s0_rdy_o   = rdy0;
   assign s1_rdy_o   = rdy1;
   assign wr_o       = wr_q;
   assign wr_data_o  = wr_data_q;
   assign busy_o     = busy_q;
   assign urun_cnt_o = urun_q;
   assign miss_cnt_o = miss_q;

endmodule

// File: tb/tb_spdif_frame_sched.sv
// Bench for spdif_frame_sched: one instance per underrun fill mode, checked every cycle
// against a queue-based frame model plus directed expectations.
module tb_spdif_frame_sched;
   localparam int PCM_W = 32;
   localparam int CNT_W = 4;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst, en, tick, clr;
   logic [PCM_W-1:0] s0_L, s0_R, s1_L, s1_R;
   logic s0_vld, s1_vld;

   logic s0_rdy_h, s1_rdy_h, wr_h, busy_h;
   logic [PCM_W-1:0] data_h;
   logic [CNT_W-1:0] urun_h, miss_h;
   logic s0_rdy_z, s1_rdy_z, wr_z, busy_z;
   logic [PCM_W-1:0] data_z;
   logic [CNT_W-1:0] urun_z, miss_z;

   always #5 clk = ~clk;

   spdif_frame_sched #(.PCM_W(PCM_W), .CNT_W(CNT_W), .URUN_HOLD(1)) dut_h (
      .clk_i(clk), .rst_i(rst), .en_i(en), .tick_i(tick),
      .s0_L_i(s0_L), .s0_R_i(s0_R), .s0_vld_i(s0_vld), .s0_rdy_o(s0_rdy_h),
      .s1_L_i(s1_L), .s1_R_i(s1_R), .s1_vld_i(s1_vld), .s1_rdy_o(s1_rdy_h),
      .wr_o(wr_h), .wr_data_o(data_h), .busy_o(busy_h),
      .urun_cnt_o(urun_h), .miss_cnt_o(miss_h), .clr_i(clr));

   spdif_frame_sched #(.PCM_W(PCM_W), .CNT_W(CNT_W), .URUN_HOLD(0)) dut_z (
      .clk_i(clk), .rst_i(rst), .en_i(en), .tick_i(tick),
      .s0_L_i(s0_L), .s0_R_i(s0_R), .s0_vld_i(s0_vld), .s0_rdy_o(s0_rdy_z),
      .s1_L_i(s1_L), .s1_R_i(s1_R), .s1_vld_i(s1_vld), .s1_rdy_o(s1_rdy_z),
      .wr_o(wr_z), .wr_data_o(data_z), .busy_o(busy_z),
      .urun_cnt_o(urun_z), .miss_cnt_o(miss_z), .clr_i(clr));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: holding buffers, last-sent pair, and a queue of words still to be written.
   bit          m_full[2];
   logic [31:0] m_bl[2], m_br[2], m_last_l[2], m_last_r[2];
   logic [31:0] wq_h[$], wq_z[$];
   bit          m_busy, m_wr;
   logic [31:0] m_data_h, m_data_z;
   int          m_urun, m_miss;

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_full[u] = 0; m_bl[u] = '0; m_br[u] = '0; m_last_l[u] = '0; m_last_r[u] = '0;
      end
      wq_h.delete(); wq_z.delete();
      m_busy = 0; m_wr = 0; m_data_h = '0; m_data_z = '0; m_urun = 0; m_miss = 0;
   endtask

   task automatic step();
      bit cons;
      bit r[2], v[2];
      logic [31:0] il[2], ir[2], fl, fr;
      int e;
      @(negedge clk);
      v[0] = s0_vld; il[0] = s0_L; ir[0] = s0_R;
      v[1] = s1_vld; il[1] = s1_L; ir[1] = s1_R;
      cons = en && tick && !m_busy;
      for (int u = 0; u < 2; u++) r[u] = en && (!m_full[u] || cons);
      chk("s0_rdy_h", s0_rdy_h, r[0]);
      chk("s1_rdy_h", s1_rdy_h, r[1]);
      chk("s0_rdy_z", s0_rdy_z, r[0]);
      chk("s1_rdy_z", s1_rdy_z, r[1]);
      if (cons) begin
         e = 0;
         for (int u = 0; u < 2; u++) begin
            if (m_full[u]) begin
               fl = m_bl[u]; fr = m_br[u];
               wq_z.push_back(fl); wq_z.push_back(fr);
            end else begin
               e++;
               fl = m_last_l[u]; fr = m_last_r[u];
               wq_z.push_back('0); wq_z.push_back('0);
            end
            wq_h.push_back(fl); wq_h.push_back(fr);
            m_last_l[u] = fl; m_last_r[u] = fr;
         end
         m_urun = (m_urun + e > SAT) ? SAT : m_urun + e;
      end
      if (en && tick && m_busy) m_miss = (m_miss + 1 > SAT) ? SAT : m_miss + 1;
      if (clr) begin m_urun = 0; m_miss = 0; end
      for (int u = 0; u < 2; u++) begin
         if (!en) m_full[u] = 0;
         else if (v[u] && r[u]) begin m_full[u] = 1; m_bl[u] = il[u]; m_br[u] = ir[u]; end
         else if (cons) m_full[u] = 0;
      end
      if (wq_h.size() > 0) begin
         m_wr = 1; m_busy = 1;
         m_data_h = wq_h.pop_front();
         m_data_z = wq_z.pop_front();
      end else begin
         m_wr = 0; m_busy = 0;
      end
      @(posedge clk); #1;
      chk("wr_h", wr_h, m_wr);
      chk("wr_z", wr_z, m_wr);
      chk("data_h", data_h, m_data_h);
      chk("data_z", data_z, m_data_z);
      chk("busy_h", busy_h, m_busy);
      chk("busy_z", busy_z, m_busy);
      chk("urun_h", urun_h, m_urun);
      chk("urun_z", urun_z, m_urun);
      chk("miss_h", miss_h, m_miss);
      chk("miss_z", miss_z, m_miss);
   endtask

   task automatic load(input bit use0, input bit use1, input logic [31:0] l0, r0, l1, r1);
      s0_L = l0; s0_R = r0; s0_vld = use0;
      s1_L = l1; s1_R = r1; s1_vld = use1;
      step();
      s0_vld = 0; s1_vld = 0;
   endtask

   task automatic tick_seq(input logic [31:0] h0, h1, h2, h3, z0, z1, z2, z3);
      logic [31:0] eh[4], ez[4];
      eh = '{h0, h1, h2, h3};
      ez = '{z0, z1, z2, z3};
      tick = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         tick = 0; s0_vld = 0; s1_vld = 0;
         chk("seq_wr", wr_h, 1);
         chk("seq_busy", busy_h, 1);
         chk("seq_data_h", data_h, eh[i]);
         chk("seq_data_z", data_z, ez[i]);
      end
      step();
      chk("seq_end_wr", wr_h, 0);
      chk("seq_end_busy", busy_h, 0);
   endtask

   initial begin
      int nw;
      rst = 1; en = 0; tick = 0; clr = 0;
      s0_L = '0; s0_R = '0; s1_L = '0; s1_R = '0; s0_vld = 0; s1_vld = 0;
      model_reset();
      @(posedge clk); #1;
      chk("rst_wr", wr_h, 0);
      chk("rst_data", data_h, 0);
      chk("rst_busy", busy_h, 0);
      chk("rst_rdy0", s0_rdy_h, 0);
      chk("rst_rdy1", s1_rdy_h, 0);
      chk("rst_urun", urun_h, 0);
      chk("rst_miss", miss_z, 0);
      @(posedge clk); #1;
      rst = 0;
      step();
      step();

      en = 1;
      step();
      chk("en_rdy0", s0_rdy_h, 1);
      chk("en_rdy1", s1_rdy_h, 1);

      // Both units loaded
      load(1, 1, 32'h11, 32'h22, 32'h33, 32'h44);
      tick_seq(32'h11, 32'h22, 32'h33, 32'h44, 32'h11, 32'h22, 32'h33, 32'h44);
      chk("urun_full", urun_h, 0);

      // Only unit 0 loaded: hold vs zero fill
      load(1, 0, 32'h55, 32'h66, 32'h0, 32'h0);
      tick_seq(32'h55, 32'h66, 32'h33, 32'h44, 32'h55, 32'h66, 32'h0, 32'h0);
      chk("urun_one", urun_h, 1);
      chk("urun_one_z", urun_z, 1);

      // Ticks at T, T+2, T+4, T+5
      load(1, 1, 32'h71, 32'h72, 32'h73, 32'h74);
      nw = 0;
      tick = 1; step(); nw += int'(wr_h);
      tick = 0; step(); nw += int'(wr_h);
      tick = 1; step(); nw += int'(wr_h);
      tick = 0; step(); nw += int'(wr_h);
      tick = 1; step(); nw += int'(wr_h);
      chk("miss_writes", nw, 4);
      chk("miss_wr_t5", wr_h, 0);
      chk("miss_cnt", miss_h, 2);
      step();
      tick = 0;
      chk("restart_wr", wr_h, 1);
      chk("restart_data", data_h, 32'h71);
      repeat (4) step();
      chk("urun_after_miss", urun_h, 3);

      // Refill on the tick cycle
      load(1, 1, 32'h81, 32'h82, 32'h83, 32'h84);
      s0_L = 32'h91; s0_R = 32'h92; s0_vld = 1;
      chk("rdy_full_before", s0_rdy_h, 0);
      tick = 1;
      #1;
      chk("rdy_refill", s0_rdy_h, 1);
      tick_seq(32'h81, 32'h82, 32'h83, 32'h84, 32'h81, 32'h82, 32'h83, 32'h84);
      tick_seq(32'h91, 32'h92, 32'h83, 32'h84, 32'h91, 32'h92, 32'h0, 32'h0);
      chk("urun_refill", urun_h, 4);

      // Disable mid-sequence
      load(1, 1, 32'hE0, 32'hE1, 32'hE2, 32'hE3);
      tick = 1; step();
      tick = 0; step();
      en = 0;
      step(); chk("dis_d2", data_h, 32'hE2);
      step(); chk("dis_d3", data_h, 32'hE3); chk("dis_wr3", wr_h, 1);
      step(); chk("dis_idle", wr_h, 0);
      chk("dis_rdy", s0_rdy_h, 0);
      tick = 1; step(); step();
      tick = 0;
      chk("dis_nowr", wr_h, 0);
      chk("dis_nomiss", miss_h, 2);
      en = 1;
      step();
      tick_seq(32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("urun_flushed", urun_h, 6);

      // Saturation and clear
      tick = 1;
      repeat (40) step();
      chk("sat_urun", urun_h, SAT);
      chk("sat_miss", miss_h, SAT);
      step();
      chk("sat_urun_hold", urun_h, SAT);
      chk("sat_miss_hold", miss_z, SAT);
      clr = 1; step(); clr = 0;
      chk("clr_urun", urun_h, 0);
      chk("clr_miss", miss_h, 0);
      tick = 0;
      repeat (5) step();

      // Reset mid-sequence
      load(1, 1, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
      tick = 1; step(); tick = 0; step();
      rst = 1; #1;
      chk("rst_mid_wr", wr_h, 0);
      chk("rst_mid_busy", busy_h, 0);
      chk("rst_mid_wr_z", wr_z, 0);
      chk("rst_mid_data", data_h, 0);
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      step();
      chk("rst_mid_after", wr_h, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         en     = ($urandom_range(0, 19) != 0);
         tick   = ($urandom_range(0, 3) == 0);
         clr    = ($urandom_range(0, 49) == 0);
         s0_vld = $urandom_range(0, 1);
         s1_vld = $urandom_range(0, 1);
         s0_L = $urandom; s0_R = $urandom; s1_L = $urandom; s1_R = $urandom;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
